// File: rtl/bananachine_ctrl_pkg.sv
// Shared encodings for the Bananachine multicycle control path:
// FSM state codes, opcode/ext-opcode classes and branch condition codes.
package bananachine_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM_RD = 3'd3,
    S_MEM_WR = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [3:0] OP_RTYPE  = 4'b0000;
  localparam logic [3:0] OP_MEMBR  = 4'b0100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_BCOND = 4'b1100;

  localparam logic [3:0] CC_EQ = 4'b0000;
  localparam logic [3:0] CC_NE = 4'b0001;
  localparam logic [3:0] CC_CS = 4'b0010;
  localparam logic [3:0] CC_CC = 4'b0011;
  localparam logic [3:0] CC_MI = 4'b0100;
  localparam logic [3:0] CC_PL = 4'b0101;
  localparam logic [3:0] CC_AL = 4'b1110;

  // Bit positions inside the {N, C, Z} flag vector.
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluator: condition code plus {N, C, Z}
// flags to a taken/not-taken bit. Unlisted codes are never taken.
module branch_cond_eval
  import bananachine_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [2:0] flags,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      CC_EQ:   cond_true = flags[FLAG_Z];
      CC_NE:   cond_true = ~flags[FLAG_Z];
      CC_CS:   cond_true = flags[FLAG_C];
      CC_CC:   cond_true = ~flags[FLAG_C];
      CC_MI:   cond_true = flags[FLAG_N];
      CC_PL:   cond_true = ~flags[FLAG_N];
      CC_AL:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Fetch/decode/execute sequencer for the Bananachine datapath.
// Optional retired-instruction counter: define MULTICYCLE_CTRL_RETIRE_CNT_EN.
module multicycle_controller
  import bananachine_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int OP_BITS  = 4,
  parameter int CNT_BITS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr,
  input  logic             mem_ready,
  input  logic [2:0]       flags,
  output logic             ir_load,
  output logic             mem_req,
  output logic             mem_we,
  output logic             addr_sel,
  output logic             alu_src_imm,
  output logic             reg_we,
  output logic             wb_sel,
  output logic             pc_inc,
  output logic             pc_load,
  output logic [2:0]       state_o
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  ,
  output logic [CNT_BITS-1:0] retired
`endif
);

  logic [2:0] state_q, state_d;

  logic [OP_BITS-1:0] op, ext;
  logic [3:0]         cond;
  logic               cond_true;
  logic               unused_b;

  assign op       = instr[WIDTH-1 -: OP_BITS];
  assign cond     = instr[WIDTH-OP_BITS-1 -: 4];
  assign ext      = instr[2*OP_BITS-1 -: OP_BITS];
  assign unused_b = ^instr[OP_BITS-1:0];

  branch_cond_eval u_cond (
    .cond      (cond),
    .flags     (flags),
    .cond_true (cond_true)
  );

  logic ir_load_c, mem_req_c, mem_we_c, addr_sel_c, alu_src_imm_c;
  logic reg_we_c, wb_sel_c, pc_inc_c, pc_load_c;

  always_comb begin
    state_d       = S_FETCH;
    ir_load_c     = 1'b0;
    mem_req_c     = 1'b0;
    mem_we_c      = 1'b0;
    addr_sel_c    = 1'b0;
    alu_src_imm_c = 1'b0;
    reg_we_c      = 1'b0;
    wb_sel_c      = 1'b0;
    pc_inc_c      = 1'b0;
    pc_load_c     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_load_c = 1'b1;
          state_d   = S_DECODE;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_DECODE: begin
        if (op == OP_MEMBR && ext == EXT_LOAD)      state_d = S_MEM_RD;
        else if (op == OP_MEMBR && ext == EXT_STOR) state_d = S_MEM_WR;
        else                                        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op == OP_RTYPE) begin
          reg_we_c = 1'b1;
          pc_inc_c = 1'b1;
        end else if (op == OP_MEMBR) begin
          if (ext == EXT_BCOND) begin
            pc_load_c = cond_true;
            pc_inc_c  = ~cond_true;
          end else begin
            pc_inc_c  = 1'b1;
          end
        end else begin
          reg_we_c      = 1'b1;
          alu_src_imm_c = 1'b1;
          pc_inc_c      = 1'b1;
        end
        state_d = S_FETCH;
      end
      S_MEM_RD: begin
        mem_req_c  = 1'b1;
        addr_sel_c = 1'b1;
        state_d    = mem_ready ? S_WB : S_MEM_RD;
      end
      S_WB: begin
        reg_we_c = 1'b1;
        wb_sel_c = 1'b1;
        pc_inc_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c  = 1'b1;
        mem_we_c   = 1'b1;
        addr_sel_c = 1'b1;
        if (mem_ready) begin
          pc_inc_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          state_d  = S_MEM_WR;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset masks every strobe immediately so an abandoned transaction
  // cannot leak a write or PC update in the cycle reset is raised.
  assign ir_load     = ir_load_c & ~reset;
  assign mem_req     = mem_req_c & ~reset;
  assign mem_we      = mem_we_c & ~reset;
  assign addr_sel    = addr_sel_c & ~reset;
  assign alu_src_imm = alu_src_imm_c & ~reset;
  assign reg_we      = reg_we_c & ~reset;
  assign wb_sel      = wb_sel_c & ~reset;
  assign pc_inc      = pc_inc_c & ~reset;
  assign pc_load     = pc_load_c & ~reset;
  assign state_o     = reset ? 3'd0 : state_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [CNT_BITS-1:0] retired_q;

  always_ff @(posedge clk) begin
    if (reset)                   retired_q <= '0;
    else if (pc_inc || pc_load)  retired_q <= retired_q + CNT_BITS'(1);
  end

  assign retired = retired_q;
`else
  localparam int unused_cnt_bits = CNT_BITS;
`endif

endmodule
